execute_alu_arbiter: RTL and testbench
======================================

# execute_alu_arbiter

Shares one Execute stage (operand-2 mux plus ALU) between two requesters: requester 0, the main pipeline's execute slot, and requester 1, an auxiliary unit such as an address or loop-count engine. Arbitration is round-robin under a valid/ready handshake. Each accepted operation gets one cycle of ALU evaluation. The result, flags and requester ID are captured in a single-entry output register that is held until the consumer accepts it.

## Interface
- WIDTH, 8, data width of operands and result
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- req_valid  in  2  bit i: requester i presents an operation
- req_ready  out  2  bit i: requester i's operation is accepted this cycle (combinational)
- req_data1  in  2*WIDTH  operand 1; requester i in bits [i*WIDTH +: WIDTH]
- req_data2  in  2*WIDTH  operand 2 (register source), same packing
- req_data3  in  2*WIDTH  operand 2 alternate (immediate), same packing
- req_alu_control  in  8  ALU operation, 4 bits per requester
- req_data2_selector  in  2  operand-2 select per requester (1 = data3)
- rsp_valid  out  1  output register holds a result
- rsp_ready  in  1  consumer accepts the result this cycle
- rsp_id  out  1  requester that issued the held result
- rsp_result  out  WIDTH  ALU result
- rsp_flags  out  4  {N, Z, V, C} from the same operation

## Operation
- The block owns one Execute instance. Its inputs are muxed from the granted requester. The Execute instance is purely combinational.
- can_accept = !rsp_valid || rsp_ready. Grants occur only when can_accept = 1.
- Grant selection when can_accept = 1:
  - Only one req_valid bit set: that requester is granted.
  - Both set: the requester selected by priority pointer `prio` is granted.
  - Neither set: no grant.
- req_ready = one-hot grant vector, or 0 when there is no grant. req_ready never depends on req_ready. It may depend on req_valid and rsp_ready.
- Handshake for requester i completes when req_valid[i] && req_ready[i].
- On a completed handshake:
  - rsp_result, rsp_flags and rsp_id load from the granted operands.
  - rsp_valid is set to 1.
  - `prio` is set to the other requester. This happens on every grant, contested or not.
- No handshake and rsp_valid && rsp_ready: rsp_valid is cleared; data registers keep their old value.
- rsp_valid && !rsp_ready: all output registers hold, and req_ready = 0.
- Requesters must hold their operands stable while valid and not ready. The arbiter does not check this.

## Timing
- Reset values: rsp_valid 0, rsp_id 0, rsp_result 0, rsp_flags 0, prio 0 (requester 0 wins the first tie). req_ready is 0 during reset.
- Latency: a handshake at edge k makes the result visible on rsp_* immediately after edge k (1 cycle).
- Throughput: one operation per cycle while rsp_ready = 1. No bubble is inserted on the drain-and-refill cycle.
- Simultaneous drain and accept in one cycle: the new result replaces the old one, and rsp_valid stays 1.
- Reset asserted mid-operation: the held result is discarded and all state returns to the reset values on that edge. Requesters re-present their operations afterwards.
- Contention with both valid every cycle and rsp_ready = 1: grants alternate 0, 1, 0, 1, …
- Backpressure: while rsp_ready = 0 and rsp_valid = 1, no requester is granted and `prio` does not advance.

## Configuration
- ALU_ARB_FIXED_PRIO_EN defined:
  - Requester 0 always wins when both are valid.
  - `prio` is not implemented.
  - Requester 1 is granted only when req_valid[0] = 0.
- Undefined (default): round-robin as described above.
- Handshake, latency and reset behaviour are identical in both builds.

## Test plan
- Reset, then idle: hold reset 2 cycles with req_valid = 2'b11 -> req_ready = 0 and rsp_valid = 0 during reset. After release, first grant is req_ready = 2'b01.
- Single request: requester 1 issues the ADD code with data1 = 8'h7F, data2 = 8'h01, selector 0 -> next cycle rsp_valid = 1, rsp_id = 1, rsp_result = 8'h80, flags N = 1, Z = 0, V = 1, C = 0.
- Operand select: requester 0 issues ADD with data1 = 8'h10, data2 = 8'h05, data3 = 8'h20, selector 1 -> rsp_result = 8'h30.
- Contention: both valid for 4 cycles with rsp_ready = 1 -> rsp_id sequence 0, 1, 0, 1. With ALU_ARB_FIXED_PRIO_EN defined -> 0, 0, 0, 0.
- Backpressure: rsp_ready = 0 for 3 cycles after one accept -> req_ready = 0, and rsp_result/flags/id stable for those 3 cycles. On the cycle rsp_ready returns to 1, a waiting request is accepted in the same cycle.
- Reset mid-stream: assert reset while rsp_valid = 1 and rsp_ready = 0 -> next cycle rsp_valid = 0 and rsp_result = 0. The next contested grant goes to requester 0.

Source files
------------

// File: rtl/execute_alu_arbiter.sv
// execute_alu_arbiter: two-requester valid/ready arbiter sharing one operand-2 mux + ALU, result held in a single-entry output register (define ALU_ARB_FIXED_PRIO_EN for fixed priority to requester 0)
module execute_alu_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         req_valid,
  output logic [1:0]         req_ready,
  input  logic [2*WIDTH-1:0] req_data1,
  input  logic [2*WIDTH-1:0] req_data2,
  input  logic [2*WIDTH-1:0] req_data3,
  input  logic [7:0]         req_alu_control,
  input  logic [1:0]         req_data2_selector,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [WIDTH-1:0]   rsp_result,
  output logic [3:0]         rsp_flags
);
  localparam int SW = $clog2(WIDTH);
  localparam logic [3:0] OP_AND = 4'h0;
  localparam logic [3:0] OP_OR  = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_XOR = 4'h3;
  localparam logic [3:0] OP_SLL = 4'h4;
  localparam logic [3:0] OP_SRL = 4'h5;
  localparam logic [3:0] OP_SUB = 4'h6;
  localparam logic [3:0] OP_SLT = 4'h7;
  localparam logic [3:0] OP_SRA = 4'h8;
  logic             r_rsp_valid;
  logic             r_rsp_id;
  logic [WIDTH-1:0] r_rsp_result;
  logic [3:0]       r_rsp_flags;
  logic             w_can_accept;
  logic [1:0]       w_grant;
  logic             w_sel;
  logic [WIDTH-1:0] w_a;
  logic [WIDTH-1:0] w_b;
  logic [3:0]       w_op;
  logic [WIDTH:0]   w_sum;
  logic [WIDTH-1:0] w_res;
  logic             w_v;
  logic             w_c;
  logic [3:0]       w_flags;
  assign w_can_accept = !r_rsp_valid || rsp_ready;
`ifdef ALU_ARB_FIXED_PRIO_EN
  assign w_grant = {req_valid[1] && !req_valid[0], req_valid[0]};
`else
  logic r_prio;
  assign w_grant = {req_valid[1] && (!req_valid[0] || r_prio),
                    req_valid[0] && (!req_valid[1] || !r_prio)};
`endif
  assign req_ready = (w_can_accept && !reset) ? w_grant : 2'b00;
  assign w_sel = w_grant[1];
  assign w_a  = w_sel ? req_data1[2*WIDTH-1:WIDTH] : req_data1[WIDTH-1:0];
  assign w_op = w_sel ? req_alu_control[7:4] : req_alu_control[3:0];
  assign w_b  = req_data2_selector[w_sel]
              ? (w_sel ? req_data3[2*WIDTH-1:WIDTH] : req_data3[WIDTH-1:0])
              : (w_sel ? req_data2[2*WIDTH-1:WIDTH] : req_data2[WIDTH-1:0]);
  // Execute stage: combinational ALU on the granted requester's operands; C is carry-out (no-borrow on SUB)
  always_comb begin
    w_sum = '0;
    w_res = '0;
    w_v   = 1'b0;
    w_c   = 1'b0;
    case (w_op)
      OP_AND: w_res = w_a & w_b;
      OP_OR:  w_res = w_a | w_b;
      OP_XOR: w_res = w_a ^ w_b;
      OP_SLL: w_res = w_a << w_b[SW-1:0];
      OP_SRL: w_res = w_a >> w_b[SW-1:0];
      OP_SRA: w_res = $signed(w_a) >>> w_b[SW-1:0];
      OP_SLT: w_res = {{(WIDTH-1){1'b0}}, $signed(w_a) < $signed(w_b)};
      OP_ADD: begin
        w_sum = {1'b0, w_a} + {1'b0, w_b};
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (w_a[WIDTH-1] == w_b[WIDTH-1]) && (w_res[WIDTH-1] != w_a[WIDTH-1]);
      end
      OP_SUB: begin
        w_sum = {1'b0, w_a} + {1'b0, ~w_b} + {{WIDTH{1'b0}}, 1'b1};
        w_res = w_sum[WIDTH-1:0];
        w_c   = w_sum[WIDTH];
        w_v   = (w_a[WIDTH-1] != w_b[WIDTH-1]) && (w_res[WIDTH-1] != w_a[WIDTH-1]);
      end
      default: w_res = '0;
    endcase
    w_flags = {w_res[WIDTH-1], w_res == '0, w_v, w_c};
  end
  // Output register: load on handshake, drain when consumed, hold under backpressure
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_id     <= 1'b0;
      r_rsp_result <= '0;
      r_rsp_flags  <= '0;
`ifndef ALU_ARB_FIXED_PRIO_EN
      r_prio       <= 1'b0;
`endif
    end else if (|req_ready) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_id     <= w_sel;
      r_rsp_result <= w_res;
      r_rsp_flags  <= w_flags;
`ifndef ALU_ARB_FIXED_PRIO_EN
      r_prio       <= ~w_sel;
`endif
    end else if (rsp_ready) begin
      r_rsp_valid  <= 1'b0;
    end
  end
  assign rsp_valid  = r_rsp_valid;
  assign rsp_id     = r_rsp_id;
  assign rsp_result = r_rsp_result;
  assign rsp_flags  = r_rsp_flags;
endmodule

// File: tb/tb_execute_alu_arbiter.sv
// tb_execute_alu_arbiter: table-driven vectors and hand sequences checked through an expected-response queue
module tb_execute_alu_arbiter;
  typedef struct packed {
    logic       id;
    logic [7:0] res;
    logic [3:0] flags;
  } rsp_t;
  typedef struct {
    logic       id;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] c;
    logic       s;
    logic [7:0] res;
    logic [3:0] fl;
  } vec_t;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  req_valid = '0;
  logic [1:0]  req_ready;
  logic [15:0] req_data1 = '0;
  logic [15:0] req_data2 = '0;
  logic [15:0] req_data3 = '0;
  logic [7:0]  req_alu_control = '0;
  logic [1:0]  req_data2_selector = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic        rsp_id;
  logic [7:0]  rsp_result;
  logic [3:0]  rsp_flags;
  rsp_t        q[$];
  rsp_t        exp_e [2];
  vec_t        vt [14];
  logic        m_valid = 1'b0;
  logic        m_prio = 1'b0;
  int          n_chk = 0;
  int          n_err = 0;
  execute_alu_arbiter #(.WIDTH(8)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_data1(req_data1), .req_data2(req_data2), .req_data3(req_data3),
    .req_alu_control(req_alu_control), .req_data2_selector(req_data2_selector),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
    .rsp_result(rsp_result), .rsp_flags(rsp_flags)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic set_op(input int i, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] c, input logic s, input logic [7:0] res, input logic [3:0] fl);
    req_data1[i*8 +: 8] = a;
    req_data2[i*8 +: 8] = b;
    req_data3[i*8 +: 8] = c;
    req_alu_control[i*4 +: 4] = op;
    req_data2_selector[i] = s;
    exp_e[i] = {i[0], res, fl};
  endtask
  // one cycle: drive, check at negedge against the model and queue, then advance past the edge
  task automatic step(input logic [1:0] v, input logic rr);
    logic [1:0] g;
    logic       can;
    req_valid = v;
    rsp_ready = rr;
    @(negedge clk);
    can = !m_valid || rr;
`ifdef ALU_ARB_FIXED_PRIO_EN
    g = !can ? 2'b00 : (v == 2'b11) ? 2'b01 : v;
`else
    g = !can ? 2'b00 : (v == 2'b11) ? (m_prio ? 2'b10 : 2'b01) : v;
`endif
    chk("req_ready", {30'b0, req_ready}, {30'b0, g});
    if (m_valid && q.size() > 0) begin
      chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
      chk("rsp_id", {31'b0, rsp_id}, {31'b0, q[0].id});
      chk("rsp_result", {24'b0, rsp_result}, {24'b0, q[0].res});
      chk("rsp_flags", {28'b0, rsp_flags}, {28'b0, q[0].flags});
      if (rr) void'(q.pop_front());
    end else begin
      chk("rsp_valid_idle", {31'b0, rsp_valid}, 32'd0);
    end
    if (|g) begin
      q.push_back(exp_e[g[1]]);
      m_valid = 1'b1;
      m_prio = ~g[1];
    end else if (rr) begin
      m_valid = 1'b0;
    end
    @(posedge clk);
    #1;
  endtask
  task automatic check_reset_state();
    chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_id", {31'b0, rsp_id}, 32'd0);
    chk("rst_result", {24'b0, rsp_result}, 32'd0);
    chk("rst_flags", {28'b0, rsp_flags}, 32'd0);
    q.delete();
    m_valid = 1'b0;
    m_prio = 1'b0;
  endtask
  initial begin
    vt[0]  = '{1'b1, 4'h2, 8'h7F, 8'h01, 8'h00, 1'b0, 8'h80, 4'b1010};
    vt[1]  = '{1'b0, 4'h2, 8'h10, 8'h05, 8'h20, 1'b1, 8'h30, 4'b0000};
    vt[2]  = '{1'b0, 4'h2, 8'hFF, 8'h01, 8'h00, 1'b0, 8'h00, 4'b0101};
    vt[3]  = '{1'b1, 4'h6, 8'h05, 8'h05, 8'h00, 1'b0, 8'h00, 4'b0101};
    vt[4]  = '{1'b0, 4'h6, 8'h80, 8'h01, 8'h00, 1'b0, 8'h7F, 4'b0011};
    vt[5]  = '{1'b1, 4'h6, 8'h01, 8'h02, 8'h00, 1'b0, 8'hFF, 4'b1000};
    vt[6]  = '{1'b0, 4'h0, 8'hF0, 8'h3C, 8'h00, 1'b0, 8'h30, 4'b0000};
    vt[7]  = '{1'b1, 4'h1, 8'h00, 8'h00, 8'h00, 1'b0, 8'h00, 4'b0100};
    vt[8]  = '{1'b0, 4'h3, 8'hAA, 8'hFF, 8'h00, 1'b0, 8'h55, 4'b0000};
    vt[9]  = '{1'b1, 4'h4, 8'h81, 8'h01, 8'h00, 1'b0, 8'h02, 4'b0000};
    vt[10] = '{1'b0, 4'h8, 8'h80, 8'h03, 8'h00, 1'b0, 8'hF0, 4'b1000};
    vt[11] = '{1'b1, 4'h7, 8'h80, 8'h01, 8'h00, 1'b0, 8'h01, 4'b0000};
    vt[12] = '{1'b0, 4'h5, 8'h80, 8'h03, 8'h00, 1'b0, 8'h10, 4'b0000};
    vt[13] = '{1'b1, 4'h2, 8'h40, 8'h00, 8'h40, 1'b1, 8'h80, 4'b1010};
    reset = 1'b1;
    req_valid = 2'b11;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("reset_req_ready", {30'b0, req_ready}, 32'd0);
      chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_state();
    set_op(0, 4'h2, 8'h01, 8'h01, 8'h00, 1'b0, 8'h02, 4'b0000);
    set_op(1, 4'h2, 8'h03, 8'h04, 8'h00, 1'b0, 8'h07, 4'b0000);
    step(2'b11, 1'b1);
    step(2'b00, 1'b1);
    for (int k = 0; k < 14; k++) begin
      set_op(int'(vt[k].id), vt[k].op, vt[k].a, vt[k].b, vt[k].c, vt[k].s, vt[k].res, vt[k].fl);
      step(vt[k].id ? 2'b10 : 2'b01, 1'b1);
    end
    step(2'b00, 1'b1);
    set_op(0, 4'h2, 8'h01, 8'h01, 8'h00, 1'b0, 8'h02, 4'b0000);
    set_op(1, 4'h2, 8'h03, 8'h04, 8'h00, 1'b0, 8'h07, 4'b0000);
    for (int k = 0; k < 4; k++) step(2'b11, 1'b1);
    step(2'b00, 1'b1);
    step(2'b01, 1'b1);
    for (int k = 0; k < 3; k++) step(2'b11, 1'b0);
    step(2'b11, 1'b1);
    step(2'b00, 1'b1);
    step(2'b10, 1'b1);
    step(2'b00, 1'b0);
    reset = 1'b1;
    req_valid = 2'b11;
    @(negedge clk);
    chk("midreset_req_ready", {30'b0, req_ready}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_reset_state();
    step(2'b11, 1'b1);
    step(2'b11, 1'b1);
    step(2'b00, 1'b1);
    step(2'b00, 1'b1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
